// File: rtl/qam_pkg.sv
// Shared definitions for the QAM test-symbol source: FSM states, pattern modes
// and the default symbol/LFSR geometry.
package qam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEED = 2'd1,
        ST_RUN  = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        MODE_PRBS  = 2'd0,
        MODE_CNT   = 2'd1,
        MODE_CONST = 2'd2,
        MODE_ALT   = 2'd3
    } mode_t;

    localparam int          DEF_SYM_BITS  = 4;
    localparam int          DEF_LFSR_LEN  = 15;
    localparam logic [14:0] DEF_LFSR_TAPS = 15'h6000;
    localparam logic [14:0] DEF_SEED      = 15'h0001;
    localparam int          DEF_CNT_W     = 16;

endpackage

// File: rtl/qam_lfsr_step.sv
// Combinational N-step Fibonacci LFSR advance; the first bit shifted out lands
// in the MSB of o_bits.
module qam_lfsr_step #(
    parameter int             LEN  = 15,
    parameter logic [LEN-1:0] TAPS = 15'h6000,
    parameter int             N    = 4
) (
    input  logic [LEN-1:0] i_state,
    output logic [LEN-1:0] o_state,
    output logic [N-1:0]   o_bits
);

    // Unrolled shift: each iteration emits the MSB and feeds back the tap parity
    always_comb begin
        logic [LEN-1:0] w_v;
        w_v    = i_state;
        o_bits = '0;
        for (int i = 0; i < N; i++) begin
            o_bits[N-1-i] = w_v[LEN-1];
            w_v = {w_v[LEN-2:0], ^(w_v & TAPS)};
        end
        o_state = w_v;
    end

endmodule

// File: rtl/qam_symbol_gen.sv
// Test-symbol source for the QAM mapper: PRBS / counter / constant / alternating
// symbols behind a valid/ready handshake, with start/stop control and a symbol counter.
module qam_symbol_gen
    import qam_pkg::*;
#(
    parameter int                  SYM_BITS  = DEF_SYM_BITS,
    parameter int                  LFSR_LEN  = DEF_LFSR_LEN,
    parameter logic [LFSR_LEN-1:0] LFSR_TAPS = DEF_LFSR_TAPS,
    parameter logic [LFSR_LEN-1:0] SEED      = DEF_SEED,
    parameter int                  CNT_W     = DEF_CNT_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_enable,
    input  logic [1:0]          i_mode,
    input  logic [SYM_BITS-1:0] i_pattern,
    input  logic                i_sym_ready,
    output logic                o_sym_valid,
    output logic [SYM_BITS-1:0] o_sym_data,
    output logic [CNT_W-1:0]    o_sym_cnt,
    output logic                o_cnt_wrap,
    output logic                o_busy
);

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [LFSR_LEN-1:0] SEED_EFF =
        (SEED == '0) ? {{(LFSR_LEN-1){1'b0}}, 1'b1} : SEED;

    state_t                r_state;
    mode_t                 r_mode;
    logic [SYM_BITS-1:0]   r_pattern;
    logic [SYM_BITS-1:0]   r_data;
    logic [LFSR_LEN-1:0]   r_lfsr;
    logic                  r_valid;
    logic                  r_busy;
    logic                  r_wrap;
    logic [CNT_W-1:0]      r_cnt;

    logic                  w_xfer;
    logic [LFSR_LEN-1:0]   w_lfsr_in;
    logic [LFSR_LEN-1:0]   w_lfsr_next;
    logic [SYM_BITS-1:0]   w_prbs_bits;
    logic [SYM_BITS-1:0]   w_next_sym;
    logic [SYM_BITS-1:0]   w_first_sym;

    qam_lfsr_step #(
        .LEN  (LFSR_LEN),
        .TAPS (LFSR_TAPS),
        .N    (SYM_BITS)
    ) u_lfsr_step (
        .i_state (w_lfsr_in),
        .o_state (w_lfsr_next),
        .o_bits  (w_prbs_bits)
    );

    // Next-symbol selection; in SEED the stepper starts from the seed value
    always_comb begin
        w_xfer = r_valid & i_sym_ready;
        if (r_state == ST_SEED) begin
            w_lfsr_in = SEED_EFF;
        end else begin
            w_lfsr_in = r_lfsr;
        end

        case (r_mode)
            MODE_PRBS:  w_next_sym = w_prbs_bits;
            MODE_CNT:   w_next_sym = r_data + SYM_BITS'(1);
            MODE_CONST: w_next_sym = r_pattern;
            MODE_ALT:   w_next_sym = ~r_data;
            default:    w_next_sym = r_data;
        endcase

        case (mode_t'(i_mode))
            MODE_PRBS:  w_first_sym = w_prbs_bits;
            MODE_CNT:   w_first_sym = '0;
            MODE_CONST: w_first_sym = i_pattern;
            MODE_ALT:   w_first_sym = i_pattern;
            default:    w_first_sym = '0;
        endcase
    end

    // Control FSM with the output holding register and delivered-symbol counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_PRBS;
            r_pattern <= '0;
            r_data    <= '0;
            r_lfsr    <= SEED_EFF;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_wrap    <= 1'b0;
            r_cnt     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_enable) begin
                        r_state <= ST_SEED;
                        r_busy  <= 1'b1;
                    end
                end
                ST_SEED: begin
                    r_lfsr    <= w_lfsr_next;
                    r_mode    <= mode_t'(i_mode);
                    r_pattern <= i_pattern;
                    r_data    <= w_first_sym;
                    r_cnt     <= '0;
                    r_wrap    <= 1'b0;
                    r_valid   <= 1'b1;
                    r_state   <= ST_RUN;
                end
                ST_RUN: begin
                    if (w_xfer) begin
                        r_cnt  <= r_cnt + CNT_W'(1);
                        r_wrap <= r_wrap | (&r_cnt);
                        r_data <= w_next_sym;
                        if (r_mode == MODE_PRBS) begin
                            r_lfsr <= w_lfsr_next;
                        end
                        if (!i_enable) begin
                            r_state <= ST_IDLE;
                            r_valid <= 1'b0;
                            r_busy  <= 1'b0;
                        end
                    end else if (!i_enable) begin
                        r_state <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    // The held symbol still has to be delivered before going idle.
                    if (w_xfer) begin
                        r_cnt   <= r_cnt + CNT_W'(1);
                        r_wrap  <= r_wrap | (&r_cnt);
                        r_state <= ST_IDLE;
                        r_valid <= 1'b0;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_valid <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_sym_valid = r_valid;
    assign o_sym_data  = r_data;
    assign o_sym_cnt   = r_cnt;
    assign o_cnt_wrap  = r_wrap;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_qam_symbol_gen.sv
// Directed + randomized bench for qam_symbol_gen: three builds (default, 4-bit
// counter, zero seed) share one stimulus and are checked against a sequence model.
module tb_qam_symbol_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        enable = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [3:0]  pattern = 4'h0;
    logic        ready = 1'b0;

    logic        a_valid, b_valid, c_valid;
    logic [3:0]  a_data, b_data, c_data;
    logic [15:0] a_cnt, c_cnt;
    logic [3:0]  b_cnt;
    logic        a_wrap, b_wrap, c_wrap;
    logic        a_busy, b_busy, c_busy;

    qam_symbol_gen dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
        .i_pattern(pattern), .i_sym_ready(ready), .o_sym_valid(a_valid),
        .o_sym_data(a_data), .o_sym_cnt(a_cnt), .o_cnt_wrap(a_wrap), .o_busy(a_busy)
    );

    qam_symbol_gen #(.CNT_W(4)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
        .i_pattern(pattern), .i_sym_ready(ready), .o_sym_valid(b_valid),
        .o_sym_data(b_data), .o_sym_cnt(b_cnt), .o_cnt_wrap(b_wrap), .o_busy(b_busy)
    );

    qam_symbol_gen #(.SEED(15'h0000)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_enable(enable), .i_mode(mode),
        .i_pattern(pattern), .i_sym_ready(ready), .o_sym_valid(c_valid),
        .o_sym_data(c_data), .o_sym_cnt(c_cnt), .o_cnt_wrap(c_wrap), .o_busy(c_busy)
    );

    always #5 clk = ~clk;

    localparam int PERIOD = 32767;

    bit         prbs_bits [PERIOD];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         m_mode  = 0;
    logic [3:0] m_pat   = 4'h0;
    int         m_k     = 0;
    bit         m_run   = 1'b0;
    logic [3:0] last_obs = 4'h0;
    logic [3:0] first4 [4] = '{4'h0, 4'h0, 4'h0, 4'h2};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected k-th accepted symbol since the last start, from the pattern rules
    function automatic logic [3:0] exp_sym(input int k);
        logic [3:0] s;
        s = 4'h0;
        case (m_mode)
            0: for (int b = 0; b < 4; b++) s[3-b] = prbs_bits[(4*k + b) % PERIOD];
            1: s = 4'(k % 16);
            2: s = m_pat;
            3: s = ((k % 2) == 1) ? ~m_pat : m_pat;
            default: s = 4'h0;
        endcase
        return s;
    endfunction

    // Called at a falling edge: drive ready, check, then cross one rising edge.
    task automatic xfer_cycle(input logic rdy);
        ready = rdy;
        #1;
        if (m_run) chk("valid_a", a_valid, 1);
        if (a_valid) begin
            chk("data_a", a_data, exp_sym(m_k));
            chk("data_seed0", c_data, exp_sym(m_k));
            last_obs = a_data;
            if (rdy) m_k++;
        end
        @(negedge clk);
    endtask

    task automatic start(input int md, input logic [3:0] pat);
        mode = 2'(md); pattern = pat; enable = 1'b1; ready = 1'b0;
        m_mode = md; m_pat = pat; m_k = 0;
        @(negedge clk);
        chk("seed_busy", a_busy, 1);
        chk("seed_valid", a_valid, 0);
        @(negedge clk);
        chk("run_valid", a_valid, 1);
        chk("run_cnt", a_cnt, 0);
        chk("run_wrap_b", b_wrap, 0);
        m_run = 1'b1;
    endtask

    task automatic stop();
        enable = 1'b0;
        xfer_cycle(1'b1);
        m_run = 1'b0;
        chk("stop_busy", a_busy, 0);
        chk("stop_valid", a_valid, 0);
        chk("stop_cnt", a_cnt, 32'(m_k % 65536));
    endtask

    initial begin
        logic [14:0] l;
        l = 15'h0001;
        for (int n = 0; n < PERIOD; n++) begin
            prbs_bits[n] = l[14];
            l = {l[13:0], l[14] ^ l[13]};
        end

        #2 rst_n = 1'b0;
        #1;
        chk("rst_valid", a_valid, 0);
        chk("rst_data", a_data, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_wrap", a_wrap, 0);
        chk("rst_busy", a_busy, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("idle_busy", a_busy, 0);

        // 1: PRBS with full throughput over a complete period
        start(0, 4'h0);
        for (int i = 0; i <= PERIOD; i++) begin
            xfer_cycle(1'b1);
            if (i < 4) chk("s1_first", last_obs, first4[i]);
            if (i == PERIOD) chk("s1_period", last_obs, first4[0]);
        end
        stop();

        // 2: counter mode under random back-pressure; mode change mid-run is ignored
        start(1, 4'h0);
        for (int i = 0; i < 120; i++) begin
            if (i == 60) begin mode = 2'd2; pattern = 4'hF; end
            xfer_cycle(1'($urandom_range(0, 1)));
        end
        chk("s2_cnt", a_cnt, 32'(m_k));
        stop();

        // 3: alternating pattern, stop while stalled, enable ignored in STOP
        start(3, 4'hA);
        for (int i = 0; i < 5; i++) xfer_cycle(1'b1);
        enable = 1'b0;
        xfer_cycle(1'b0);
        chk("s3_stop_busy", a_busy, 1);
        enable = 1'b1;
        xfer_cycle(1'b0);
        xfer_cycle(1'b0);
        xfer_cycle(1'b1);
        m_run = 1'b0;
        enable = 1'b0;
        chk("s3_idle_busy", a_busy, 0);
        chk("s3_idle_valid", a_valid, 0);
        chk("s3_cnt", a_cnt, 32'(m_k));
        @(negedge clk);
        chk("s3_stays_idle", a_busy, 0);

        // 4: constant pattern, 4-bit counter wraps and the flag sticks
        start(2, 4'h3);
        for (int i = 0; i < 16; i++) begin
            xfer_cycle(1'b1);
            if (i == 14) chk("s4_nowrap_b", b_wrap, 0);
        end
        chk("s4_cnt_b", b_cnt, 0);
        chk("s4_wrap_b", b_wrap, 1);
        chk("s4_cnt_a", a_cnt, 16);
        chk("s4_wrap_a", a_wrap, 0);
        stop();
        chk("s4_wrap_b_idle", b_wrap, 1);
        start(2, 4'h3);
        stop();

        // 5: asynchronous reset mid-stream, then a clean PRBS restart
        start(0, 4'h0);
        for (int i = 0; i < 5; i++) xfer_cycle(1'b1);
        ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        m_run = 1'b0;
        chk("s5_valid", a_valid, 0);
        chk("s5_data", a_data, 0);
        chk("s5_cnt", a_cnt, 0);
        chk("s5_busy", a_busy, 0);
        chk("s5_seed0_valid", c_valid, 0);
        enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start(0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            xfer_cycle(1'b1);
            chk("s5_first", last_obs, first4[i]);
        end
        stop();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
